fila_leitor: RTL

Read-side controller for the 8-entry `fila` queue. It watches the queue occupancy and issues single-cycle dequeue pulses that respect the queue's two-edge dequeue latency. It captures each popped byte and presents it to a downstream consumer with a valid/ack handshake. It sits between the queue's `data_out`/`len_out` and the display/consumer logic, in the same `clk_10KHz` domain.

---
 rtl/fila_leitor.sv | 92 +++++++++
 1 files changed

// File: rtl/fila_leitor.sv
// Read-side controller for the 8-entry fila queue: issues one-cycle dequeue pulses,
// waits out the queue's two-edge latency, and hands each byte to a valid/ack consumer.
module fila_leitor #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 4
) (
    input  logic              clk_10KHz,
    input  logic              reset,
    input  logic [LEN_W-1:0]  len_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              dequeue_out,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    input  logic              ack_in,
    output logic              busy_out,
    output logic [7:0]        count_out
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StCapture,
        StPresent
    } state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic              r_dequeue;
    logic              w_dequeue_d;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_data_d;
    logic              r_valid;
    logic              w_valid_d;
    logic [7:0]        r_count;
    logic [7:0]        w_count_d;

    always_ff @(posedge clk_10KHz) begin
        if (reset) begin
            r_state   <= StIdle;
            r_dequeue <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_count   <= 8'd0;
        end else begin
            r_state   <= w_state_d;
            r_dequeue <= w_dequeue_d;
            r_data    <= w_data_d;
            r_valid   <= w_valid_d;
            r_count   <= w_count_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_dequeue_d = 1'b0;
        w_data_d    = r_data;
        w_valid_d   = r_valid;
        w_count_d   = r_count;
        unique case (r_state)
            StIdle: begin
                if (len_in != '0) begin
                    w_state_d   = StReq;
                    w_dequeue_d = 1'b1;
                end
            end
            // Request drops after one cycle; a held request would pop a second byte.
            StReq:  w_state_d = StWait;
            StWait: w_state_d = StCapture;
            StCapture: begin
                w_data_d  = data_in;
                w_valid_d = 1'b1;
                w_count_d = r_count + 8'd1;
                w_state_d = StPresent;
            end
            StPresent: begin
                if (ack_in) begin
                    w_valid_d = 1'b0;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign dequeue_out = r_dequeue;
    assign data_out    = r_data;
    assign valid_out   = r_valid;
    assign count_out   = r_count;
    assign busy_out    = (r_state != StIdle);

endmodule
